// File: rtl/pll_supply_ramp.sv
// pll_supply_ramp
// ---------------------------------------------------------------------------
// Ramps a PLL supply rail from its present voltage to a requested target in
// fixed STEP_UV increments, one step every STEP_CYCLES clocks. After the
// target is reached it waits SETTLE_CYCLES clocks before the rail is
// considered settled and returns to IDLE.
//
// Optional feature (compile-time macro PLL_SUPPLY_RAMP_CLAMP_EN):
//   defined   -> a requested target above ON_MAX_UV is clamped to ON_MAX_UV
//   undefined -> the requested target is latched unmodified
//
// Ports
//   clk_i            single clock
//   rst_ni           synchronous active-low reset
//   req_valid_i      new target request
//   req_ready_o      request can be accepted (high only in IDLE)
//   req_target_uv_i  unsigned target voltage in uV
//   vout_uv_o        driven (registered) supply voltage in uV
//   vout_on_o        1 while ON_MIN_UV <= vout_uv_o <= ON_MAX_UV
//   busy_o           ramp or settle in progress
//   pwr_good_o       idle, settled at least once, and inside the ON window
//   done_o           one-cycle pulse on the last SETTLE cycle
//   state_o          debug view of the FSM state (pll_ramp_state_e encoding)
//
// Handshake: a request transfers on a rising clk_i edge where
// req_valid_i && req_ready_o. req_ready_o is high only in IDLE, so requests
// presented while busy are simply not taken; there is no queueing and the
// requester may drop or change req_valid_i/req_target_uv_i at any time before
// the transfer.
// ---------------------------------------------------------------------------
module pll_supply_ramp #(
  parameter int unsigned STEP_UV       = 10000,
  parameter int unsigned STEP_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ON_MIN_UV     = 810000,
  parameter int unsigned ON_MAX_UV     = 1320000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_target_uv_i,
  output logic [31:0] vout_uv_o,
  output logic        vout_on_o,
  output logic        busy_o,
  output logic        pwr_good_o,
  output logic        done_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    SETTLE    = 2'd3
  } pll_ramp_state_e;

  localparam logic [32:0] STEP_33     = 33'(STEP_UV);
  localparam logic [31:0] STEP_32     = 32'(STEP_UV);
  localparam logic [31:0] STEP_LAST   = 32'(STEP_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  pll_ramp_state_e state_q, state_d;
  logic [31:0]     vout_q, vout_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     target_q, target_d;
  logic            settled_q, settled_d;

  logic            accept;
  logic [31:0]     target_in;
  logic [32:0]     up_dist;
  logic [32:0]     down_dist;
  logic [32:0]     new_target_33;
  logic [32:0]     vout_33;

  // Target as it will be latched on acceptance.
`ifdef PLL_SUPPLY_RAMP_CLAMP_EN
  assign target_in = (req_target_uv_i > 32'(ON_MAX_UV)) ? 32'(ON_MAX_UV) : req_target_uv_i;
`else
  assign target_in = req_target_uv_i;
`endif

  // All distance math is done at 33 bits so comparisons never wrap.
  assign vout_33       = {1'b0, vout_q};
  assign new_target_33 = {1'b0, target_in};
  assign up_dist       = {1'b0, target_q} - vout_33;
  assign down_dist     = vout_33 - {1'b0, target_q};

  assign accept = req_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      vout_q    <= '0;
      cnt_q     <= '0;
      target_q  <= '0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vout_q    <= vout_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      settled_q <= settled_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vout_d    = vout_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    settled_d = settled_q;
    done_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = target_in;
          cnt_d    = '0;
          if (new_target_33 > vout_33) begin
            state_d = RAMP_UP;
          end else if (new_target_33 < vout_33) begin
            state_d = RAMP_DOWN;
          end else begin
            state_d = SETTLE;
          end
        end
      end

      // The step counter starts at 0 on acceptance, so the first step
      // lands STEP_CYCLES edges after the accepting edge.
      RAMP_UP: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (up_dist <= STEP_33) begin
            vout_d  = target_q;
            state_d = SETTLE;
          end else begin
            vout_d = vout_q + STEP_32;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // Snapping to the target when within one step also guarantees vout
      // never goes below the target (and therefore never below 0).
      RAMP_DOWN: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (down_dist <= STEP_33) begin
            vout_d  = target_q;
            state_d = SETTLE;
          end else begin
            vout_d = vout_q - STEP_32;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          settled_d = 1'b1;
          done_o    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign vout_uv_o   = vout_q;
  assign vout_on_o   = (vout_q >= 32'(ON_MIN_UV)) && (vout_q <= 32'(ON_MAX_UV));
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  // Power-good drops in the same cycle a new request is being accepted.
  assign pwr_good_o  = (state_q == IDLE) && settled_q && vout_on_o && !accept;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pll_supply_ramp.sv
// tb_pll_supply_ramp
// Directed bench for pll_supply_ramp with default parameters. Each request
// step runs a small cycle-by-cycle model of the rail (step every 4 cycles,
// 10000 uV per step, snap on the last partial step, 8 settle cycles) and
// compares every observable output; the cycle at which the target is first
// reached is also compared against a hand-computed value.
module tb_pll_supply_ramp;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_target_uv_i;
  logic [31:0] vout_uv_o;
  logic        vout_on_o;
  logic        busy_o;
  logic        pwr_good_o;
  logic        done_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  // Model of the rail voltage, maintained by the bench only.
  logic [31:0] model_v = '0;

  pll_supply_ramp dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_target_uv_i (req_target_uv_i),
    .vout_uv_o       (vout_uv_o),
    .vout_on_o       (vout_on_o),
    .busy_o          (busy_o),
    .pwr_good_o      (pwr_good_o),
    .done_o          (done_o),
    .state_o         (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic on_window(input logic [31:0] v);
    return (v >= 32'd810000) && (v <= 32'd1320000);
  endfunction

  // Issue one request and follow it to IDLE, checking every cycle.
  // final_v  : voltage the rail must end at (after any clamping)
  // exp_land : hand-computed cycle (after the accepting edge) at which
  //            vout first equals final_v (0 for an equal target)
  // hold_busy: keep req_valid_i high with 500000 while busy
  task automatic request(input logic [31:0] tgt, input logic [31:0] final_v,
                         input int exp_land, input bit hold_busy, input string tag);
    int land;
    int obs_land;
    bit exp_busy;
    logic [1:0] exp_state1;
    req_valid_i     = 1'b1;
    req_target_uv_i = tgt;
    #1;
    chk({tag, "_ready_at_req"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_pg_clear_on_accept"}, 32'(pwr_good_o), 32'd0);
    if (final_v > model_v)      exp_state1 = 2'd1;
    else if (final_v < model_v) exp_state1 = 2'd2;
    else                        exp_state1 = 2'd3;
    step(1);  // accepting edge, cycle 0
    if (hold_busy) req_target_uv_i = 32'd500000;
    else           req_valid_i     = 1'b0;
    land     = (model_v == final_v) ? 0 : -1;
    obs_land = (vout_uv_o == final_v) ? 0 : -1;
    for (int k = 1; k < 2000; k++) begin
      step(1);
      if (land < 0 && (k % 4) == 0) begin
        if (final_v > model_v)
          model_v = (final_v - model_v <= 32'd10000) ? final_v : model_v + 32'd10000;
        else
          model_v = (model_v - final_v <= 32'd10000) ? final_v : model_v - 32'd10000;
        if (model_v == final_v) land = k;
      end
      if (obs_land < 0 && vout_uv_o == final_v) obs_land = k;
      exp_busy = (land < 0) || (k < land + 8);
      if (k == 1) chk({tag, "_state_k1"}, 32'(state_o), 32'(exp_state1));
      chk({tag, "_vout"},     vout_uv_o,            model_v);
      chk({tag, "_vout_on"},  32'(vout_on_o),       32'(on_window(model_v)));
      chk({tag, "_busy"},     32'(busy_o),          32'(exp_busy));
      chk({tag, "_ready"},    32'(req_ready_o),     32'(!exp_busy));
      chk({tag, "_done"},     32'(done_o),          32'(land >= 0 && k == land + 7));
      chk({tag, "_pwr_good"}, 32'(pwr_good_o),      32'(!exp_busy && on_window(model_v)));
      // Drop the held request while still settling so it is never taken.
      if (land >= 0) req_valid_i = 1'b0;
      if (land >= 0 && k == land + 9) break;
    end
    chk({tag, "_land_cycle"}, 32'(obs_land), 32'(exp_land));
    chk({tag, "_end_idle"},   32'(state_o),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni          = 1'b0;
    req_valid_i     = 1'b0;
    req_target_uv_i = '0;
    step(2);

    // Reset values while reset is held (valid high must not be taken).
    req_valid_i     = 1'b1;
    req_target_uv_i = 32'd700000;
    step(1);
    chk("rst_vout",     vout_uv_o,         32'd0);
    chk("rst_ready",    32'(req_ready_o),  32'd1);
    chk("rst_vout_on",  32'(vout_on_o),    32'd0);
    chk("rst_busy",     32'(busy_o),       32'd0);
    chk("rst_pwr_good", 32'(pwr_good_o),   32'd0);
    chk("rst_done",     32'(done_o),       32'd0);
    chk("rst_state",    32'(state_o),      32'd0);
    req_valid_i = 1'b0;
    rst_ni      = 1'b1;
    step(2);
    chk("idle_no_pg_before_settle", 32'(pwr_good_o), 32'd0);
    chk("idle_vout_hold", vout_uv_o, 32'd0);

    // Basic ramp 0 -> 900000: 90 steps, lands at cycle 360.
    request(32'd900000, 32'd900000, 360, 1'b0, "basic");
    // Partial final step 900000 -> 895000: single step at cycle 4.
    request(32'd895000, 32'd895000, 4, 1'b0, "partial");
    // Equal target: straight to settle.
    request(32'd895000, 32'd895000, 0, 1'b0, "equal");
    // Requests while busy are ignored: 895000 -> 1000000 takes 11 steps.
    request(32'd1000000, 32'd1000000, 44, 1'b1, "busy_req");
    // Ramp down 1000000 -> 800000: 20 steps, leaves the ON window.
    request(32'd800000, 32'd800000, 80, 1'b0, "down");

    // Reset mid-ramp: from 0 toward 600000, reset at vout=400000.
    rst_ni = 1'b0;
    step(1);
    rst_ni = 1'b1;
    model_v = '0;
    req_valid_i     = 1'b1;
    req_target_uv_i = 32'd600000;
    step(1);
    req_valid_i = 1'b0;
    step(160);
    chk("midrst_vout_before", vout_uv_o, 32'd400000);
    chk("midrst_busy_before", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    step(1);
    chk("midrst_vout",     vout_uv_o,        32'd0);
    chk("midrst_state",    32'(state_o),     32'd0);
    chk("midrst_done",     32'(done_o),      32'd0);
    chk("midrst_busy",     32'(busy_o),      32'd0);
    chk("midrst_ready",    32'(req_ready_o), 32'd1);
    chk("midrst_pwr_good", 32'(pwr_good_o),  32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("midrst_no_done_after", 32'(done_o), 32'd0);
      chk("midrst_stay_idle",     32'(vout_uv_o), 32'd0);
    end

    // Over-range target.
`ifdef PLL_SUPPLY_RAMP_CLAMP_EN
    request(32'd1500000, 32'd1320000, 528, 1'b0, "clamp");
    chk("clamp_final_vout", vout_uv_o,        32'd1320000);
    chk("clamp_final_on",   32'(vout_on_o),   32'd1);
    chk("clamp_final_pg",   32'(pwr_good_o),  32'd1);
`else
    request(32'd1500000, 32'd1500000, 600, 1'b0, "noclamp");
    chk("noclamp_final_vout", vout_uv_o,       32'd1500000);
    chk("noclamp_final_on",   32'(vout_on_o),  32'd0);
    chk("noclamp_final_pg",   32'(pwr_good_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
